// File: rtl/key_event.sv
// Classifies a debounced key level into single-cycle press, release, click,
// double-click, long-press and auto-repeat pulses. All outputs are registered.
module key_event #(
  parameter int              NBITS         = 24,
  parameter logic [NBITS-1:0] LONG_CYCLES   = 24'd5_000_000,
  parameter logic [NBITS-1:0] DOUBLE_GAP    = 24'd2_500_000,
  parameter logic [NBITS-1:0] REPEAT_CYCLES = 24'd1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic press_o,
  output logic release_o,
  output logic short_o,
  output logic double_o,
  output logic long_o,
  output logic repeat_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DOWN1 = 3'd1;
  localparam logic [2:0] S_WAIT2 = 3'd2;
  localparam logic [2:0] S_DOWN2 = 3'd3;
  localparam logic [2:0] S_HELD  = 3'd4;

  localparam logic [NBITS-1:0] LONG_MATCH   = LONG_CYCLES - NBITS'(2);
  localparam logic [NBITS-1:0] GAP_MATCH    = DOUBLE_GAP - NBITS'(2);
  // HELD is entered with cnt cleared on the long_o edge, so matching one
  // later spaces every repeat_o exactly REPEAT_CYCLES apart.
  localparam logic [NBITS-1:0] REPEAT_MATCH = REPEAT_CYCLES - NBITS'(1);

  logic             key_d_q;
  logic [2:0]       state_q, state_d;
  logic [NBITS-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             short_q, short_d;
  logic             double_q, double_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             rise, fall;

  assign rise = key_i & ~key_d_q;
  assign fall = ~key_i & key_d_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + NBITS'(1);
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    double_d  = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          press_d = 1'b1;
          state_d = S_DOWN1;
          cnt_d   = '0;
        end
      end
      S_DOWN1: begin
        if (fall) begin
          release_d = 1'b1;
          state_d   = S_WAIT2;
          cnt_d     = '0;
        end else if (cnt_q == LONG_MATCH) begin
          long_d  = 1'b1;
          state_d = S_HELD;
          cnt_d   = '0;
        end
      end
      S_WAIT2: begin
        if (rise) begin
          press_d = 1'b1;
          state_d = S_DOWN2;
          cnt_d   = '0;
        end else if (cnt_q == GAP_MATCH) begin
          short_d = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_DOWN2: begin
        // No long-press here: a held second press only defers double_o.
        if (fall) begin
          release_d = 1'b1;
          double_d  = 1'b1;
          state_d   = S_IDLE;
          cnt_d     = '0;
        end
      end
      S_HELD: begin
        if (fall) begin
          release_d = 1'b1;
          state_d   = S_IDLE;
          cnt_d     = '0;
        end else if (cnt_q == REPEAT_MATCH) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_d_q   <= 1'b0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      key_d_q   <= key_i;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      short_q   <= short_d;
      double_q  <= double_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  assign press_o   = press_q;
  assign release_o = release_q;
  assign short_o   = short_q;
  assign double_o  = double_q;
  assign long_o    = long_q;
  assign repeat_o  = repeat_q;

endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event: expected pulses are queued with their due
// cycle when stimulus is issued and checked against the outputs every cycle.
module tb_key_event;

  localparam int          NB = 24;
  localparam logic [23:0] LC = 24'd8;
  localparam logic [23:0] DG = 24'd6;
  localparam logic [23:0] RC = 24'd4;

  // Output vector bit order: {press, release, short, double, long, repeat}
  localparam logic [5:0] B_PRESS   = 6'b100000;
  localparam logic [5:0] B_RELEASE = 6'b010000;
  localparam logic [5:0] B_SHORT   = 6'b001000;
  localparam logic [5:0] B_DOUBLE  = 6'b000100;
  localparam logic [5:0] B_LONG    = 6'b000010;
  localparam logic [5:0] B_REPEAT  = 6'b000001;

  logic clk = 1'b0;
  logic rst_n;
  logic key_i;
  logic press_o, release_o, short_o, double_o, long_o, repeat_o;

  typedef struct {
    int         due;
    logic [5:0] vec;
  } exp_t;

  exp_t  sb[$];
  int    cyc    = 0;
  int    checks = 0;
  int    errors = 0;
  int    p;
  string scen   = "init";

  key_event #(
    .NBITS        (NB),
    .LONG_CYCLES  (LC),
    .DOUBLE_GAP   (DG),
    .REPEAT_CYCLES(RC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_i    (key_i),
    .press_o  (press_o),
    .release_o(release_o),
    .short_o  (short_o),
    .double_o (double_o),
    .long_o   (long_o),
    .repeat_o (repeat_o)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input int due, input logic [5:0] vec);
    exp_t e;
    e.due = due;
    e.vec = vec;
    sb.push_back(e);
  endtask

  // Drive inputs for the next rising edge, then compare the outputs that edge produced.
  task automatic tick(input logic k, input logic r);
    logic [5:0] expv;
    logic [5:0] obs;
    key_i = k;
    rst_n = r;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    expv = '0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        expv |= sb[i].vec;
        sb.delete(i);
      end
    end
    obs = {press_o, release_o, short_o, double_o, long_o, repeat_o};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %b expected %b", scen, cyc, obs, expv);
    end
  endtask

  task automatic run(input logic k, input logic r, input int n);
    for (int i = 0; i < n; i++) tick(k, r);
  endtask

  initial begin
    rst_n = 1'b0;
    key_i = 1'b0;

    scen = "reset_hold";
    for (int i = 0; i < 5; i++) tick(i[0], 1'b0);
    scen = "reset_release_idle";
    run(1'b0, 1'b1, 4);

    scen = "short_click";
    p = cyc + 1;
    push_exp(p, B_PRESS);
    push_exp(p + 3, B_RELEASE);
    push_exp(p + 8, B_SHORT);
    run(1'b1, 1'b1, 3);
    run(1'b0, 1'b1, 10);

    scen = "double_click";
    p = cyc + 1;
    push_exp(p, B_PRESS);
    push_exp(p + 2, B_RELEASE);
    push_exp(p + 5, B_PRESS);
    push_exp(p + 7, B_RELEASE | B_DOUBLE);
    run(1'b1, 1'b1, 2);
    run(1'b0, 1'b1, 3);
    run(1'b1, 1'b1, 2);
    run(1'b0, 1'b1, 10);

    scen = "long_repeat";
    p = cyc + 1;
    push_exp(p, B_PRESS);
    push_exp(p + 7, B_LONG);
    push_exp(p + 11, B_REPEAT);
    push_exp(p + 15, B_REPEAT);
    push_exp(p + 19, B_REPEAT);
    push_exp(p + 20, B_RELEASE);
    run(1'b1, 1'b1, 20);
    run(1'b0, 1'b1, 10);

    scen = "long_threshold_release";
    p = cyc + 1;
    push_exp(p, B_PRESS);
    push_exp(p + 7, B_RELEASE);
    push_exp(p + 12, B_SHORT);
    run(1'b1, 1'b1, 7);
    run(1'b0, 1'b1, 10);

    scen = "gap_edge_press";
    p = cyc + 1;
    push_exp(p, B_PRESS);
    push_exp(p + 2, B_RELEASE);
    push_exp(p + 7, B_PRESS);
    push_exp(p + 9, B_RELEASE | B_DOUBLE);
    run(1'b1, 1'b1, 2);
    run(1'b0, 1'b1, 5);
    run(1'b1, 1'b1, 2);
    run(1'b0, 1'b1, 8);

    scen = "gap_expired_then_press";
    p = cyc + 1;
    push_exp(p, B_PRESS);
    push_exp(p + 2, B_RELEASE);
    push_exp(p + 7, B_SHORT);
    push_exp(p + 8, B_PRESS);
    push_exp(p + 10, B_RELEASE);
    push_exp(p + 15, B_SHORT);
    run(1'b1, 1'b1, 2);
    run(1'b0, 1'b1, 6);
    run(1'b1, 1'b1, 2);
    run(1'b0, 1'b1, 10);

    scen = "reset_in_wait2";
    p = cyc + 1;
    push_exp(p, B_PRESS);
    push_exp(p + 2, B_RELEASE);
    run(1'b1, 1'b1, 2);
    run(1'b0, 1'b1, 2);
    run(1'b0, 1'b0, 2);
    run(1'b0, 1'b1, 12);

    scen = "click_after_reset";
    p = cyc + 1;
    push_exp(p, B_PRESS);
    push_exp(p + 3, B_RELEASE);
    push_exp(p + 8, B_SHORT);
    run(1'b1, 1'b1, 3);
    run(1'b0, 1'b1, 10);

    scen = "key_high_at_reset_release";
    run(1'b1, 1'b0, 3);
    p = cyc + 1;
    push_exp(p, B_PRESS);
    push_exp(p + 3, B_RELEASE);
    push_exp(p + 8, B_SHORT);
    run(1'b1, 1'b1, 3);
    run(1'b0, 1'b1, 10);

    scen = "scoreboard_drained";
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL %s: observed %0d pending expected 0", scen, sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
